// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: gathers qualified serial bits into WIDTH-bit
// words and presents them on a valid/ready holding register with a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_complete;
  logic             w_take;
  logic             w_load;
  logic             w_drop;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shift_nxt = {r_shift[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign w_shift_nxt = {bit_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // A frame_start bit always opens a new word, so it can never complete one.
  assign w_complete = bit_valid & ~frame_start & (r_count == LAST_CNT);
  assign w_take     = r_valid & out_ready;
  assign w_load     = w_complete & (~r_valid | out_ready);
  assign w_drop     = w_complete & r_valid & ~out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (bit_valid) begin
      r_shift <= w_shift_nxt;
      if (frame_start)     r_count <= ONE_CNT;
      else if (w_complete) r_count <= '0;
      else                 r_count <= r_count + ONE_CNT;
    end else if (frame_start) begin
      r_count <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_shift_nxt;
        r_valid <= 1'b1;
      end else if (w_take) begin
        r_valid <= 1'b0;
      end
      // A new drop outranks a coincident clear.
      if (w_drop)           r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;
  assign bit_count = r_count;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a queue-based word model, plus directed cases.
module tb_sipo_deserializer;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset, bit_in, bit_valid, frame_start, clr_overrun, out_ready;
  logic [W-1:0]  data_m, data_l;
  logic          valid_m, valid_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .clr_overrun(clr_overrun), .out_data(data_m),
    .out_valid(valid_m), .out_ready(out_ready), .overrun(ovr_m), .bit_count(cnt_m));

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .clr_overrun(clr_overrun), .out_data(data_l),
    .out_valid(valid_l), .out_ready(out_ready), .overrun(ovr_l), .bit_count(cnt_l));

  // Reference model: received bits of the partial word in arrival order.
  bit           m_bits[$];
  logic [W-1:0] m_data_m, m_data_l;
  logic         m_valid, m_ovr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk_word(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = m_bits[i];
      else     w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_step(input logic rst, input logic bv, input logic bi,
                            input logic fs, input logic clr, input logic rdy);
    bit comp, drop;
    logic [W-1:0] wm, wl;
    comp = 0; drop = 0; wm = '0; wl = '0;
    if (rst) begin
      m_bits.delete();
      m_data_m = '0; m_data_l = '0; m_valid = 0; m_ovr = 0;
      return;
    end
    if (bv) begin
      if (fs) m_bits.delete();
      m_bits.push_back(bi);
      if (m_bits.size() == W) begin
        comp = 1;
        wm = mk_word(1'b1);
        wl = mk_word(1'b0);
        m_bits.delete();
      end
    end else if (fs) begin
      m_bits.delete();
    end
    if (comp) begin
      if (!m_valid || rdy) begin
        m_data_m = wm; m_data_l = wl; m_valid = 1;
      end else begin
        drop = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (drop)     m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic cyc(input logic rst, input logic bv, input logic bi,
                     input logic fs, input logic clr, input logic rdy);
    reset = rst; bit_valid = bv; bit_in = bi; frame_start = fs;
    clr_overrun = clr; out_ready = rdy;
    @(posedge clk);
    model_step(rst, bv, bi, fs, clr, rdy);
    #1;
    chk("data_msb",  64'(data_m),  64'(m_data_m));
    chk("data_lsb",  64'(data_l),  64'(m_data_l));
    chk("valid_msb", 64'(valid_m), 64'(m_valid));
    chk("valid_lsb", 64'(valid_l), 64'(m_valid));
    chk("ovr_msb",   64'(ovr_m),   64'(m_ovr));
    chk("ovr_lsb",   64'(ovr_l),   64'(m_ovr));
    chk("cnt_msb",   64'(cnt_m),   64'(m_bits.size()));
    chk("cnt_lsb",   64'(cnt_l),   64'(m_bits.size()));
  endtask

  // Sends a word first-bit = w[W-1] (so the MSB-first instance reproduces w).
  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = W - 1; i >= 0; i--) cyc(0, 1, w[i], 0, 0, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    logic [W-1:0] a5;
    a5 = 8'hA5;
    m_data_m = '0; m_data_l = '0; m_valid = 0; m_ovr = 0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_data", 64'(data_m), 64'(0));
    chk("rst_cnt",  64'(cnt_m),  64'(0));
    idle(1, 1);

    // 0xA5 with out_ready=1; word visible for one cycle
    for (int i = W - 1; i >= 0; i--) begin
      cyc(0, 1, a5[i], 0, 0, 1);
      if (i > 0) chk("a5_cnt_seq", 64'(cnt_m), 64'(W - i));
    end
    chk("a5_msb",       64'(data_m),  64'(8'hA5));
    chk("a5_lsb",       64'(data_l),  64'(8'hA5));
    chk("a5_valid",     64'(valid_m), 64'(1));
    chk("a5_cnt_wrap",  64'(cnt_m),   64'(0));
    idle(1, 1);
    chk("a5_one_cycle", 64'(valid_m), 64'(0));

    // Gap of 3 idle cycles mid-word
    for (int i = W - 1; i >= 4; i--) cyc(0, 1, a5[i], 0, 0, 0);
    idle(3, 0);
    chk("gap_no_early", 64'(valid_l), 64'(0));
    chk("gap_cnt_hold", 64'(cnt_l),   64'(4));
    for (int i = 3; i >= 0; i--) cyc(0, 1, a5[i], 0, 0, 0);
    chk("gap_lsb", 64'(data_l), 64'(8'hA5));
    idle(1, 1);

    // Backpressure and overrun
    send_word(8'h3C, 0);
    send_word(8'hC3, 0);
    chk("bp_hold", 64'(data_m), 64'(8'h3C));
    chk("bp_ovr",  64'(ovr_m),  64'(1));
    cyc(0, 0, 0, 0, 1, 0);
    chk("bp_clr",  64'(ovr_m),  64'(0));
    idle(1, 1);
    chk("bp_drain", 64'(valid_m), 64'(0));
    chk("bp_keep",  64'(data_m),  64'(8'h3C));

    // Simultaneous drain and completion
    send_word(8'h11, 0);
    for (int i = W - 1; i >= 1; i--) cyc(0, 1, 1'(8'h22 >> i), 0, 0, 0);
    cyc(0, 1, 1'b0, 0, 0, 1);
    chk("b2b_data",  64'(data_m),  64'(8'h22));
    chk("b2b_lsb",   64'(data_l),  64'(8'h44));
    chk("b2b_valid", 64'(valid_m), 64'(1));
    chk("b2b_ovr",   64'(ovr_m),   64'(0));
    idle(1, 1);

    // Re-alignment: 5 bits, frame_start bit, then 7 bits -> 0x81
    for (int i = 0; i < 5; i++) cyc(0, 1, 1'b1, 0, 0, 1);
    cyc(0, 1, 1'b1, 1, 0, 1);
    chk("fs_cnt", 64'(cnt_m), 64'(1));
    for (int i = 0; i < 6; i++) cyc(0, 1, 1'b0, 0, 0, 1);
    chk("fs_no_partial", 64'(valid_m), 64'(0));
    cyc(0, 1, 1'b1, 0, 0, 1);
    chk("fs_word", 64'(data_m), 64'(8'h81));

    // frame_start with bit_valid at count WIDTH-1: no completion
    idle(1, 1);
    for (int i = 0; i < W - 1; i++) cyc(0, 1, 1'b1, 0, 0, 1);
    cyc(0, 1, 1'b0, 1, 0, 1);
    chk("fs_last_nocomp", 64'(valid_m), 64'(0));
    chk("fs_last_cnt",    64'(cnt_m),   64'(1));

    // Reset mid-word
    cyc(0, 1, 1'b1, 0, 0, 1);
    cyc(1, 1, 1'b1, 0, 0, 1);
    chk("rst_mid_cnt", 64'(cnt_m), 64'(0));
    for (int i = 0; i < W - 2; i++) cyc(0, 1, 1'b1, 0, 0, 1);
    chk("rst_mid_noword", 64'(valid_m), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
